// File: rtl/fft8_frame_ctrl_pkg.sv
// Shared definitions for the 8-point FFT frame controller: FSM encoding,
// transform size and the radix-2 bit-reversed index order.
package fft8_frame_ctrl_pkg;

    localparam int N     = 8;
    localparam int LOG2N = 3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_CAP  = 1'b1
    } state_t;

    // Output slot i receives natural-order sample x[BITREV_IDX[i]].
    localparam logic [LOG2N-1:0] BITREV_IDX [N] = '{
        3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7
    };

endpackage

// File: rtl/fft8_frame_ctrl_if.sv
// Frame hand-off bus between the frame controller (master) and the FFT core (slave).
interface fft8_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] frame_0;
    logic [WIDTH-1:0] frame_1;
    logic [WIDTH-1:0] frame_2;
    logic [WIDTH-1:0] frame_3;
    logic [WIDTH-1:0] frame_4;
    logic [WIDTH-1:0] frame_5;
    logic [WIDTH-1:0] frame_6;
    logic [WIDTH-1:0] frame_7;
    logic             frame_valid;
    logic             frame_ready;

    modport master (
        output frame_0, frame_1, frame_2, frame_3,
        output frame_4, frame_5, frame_6, frame_7,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_0, frame_1, frame_2, frame_3,
        input  frame_4, frame_5, frame_6, frame_7,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/fft8_bitrev.sv
// Combinational bit-reversal permutation: natural-order x[0..7] to radix-2 DIT
// input order. Also usable by the output reorder stage.
module fft8_bitrev
    import fft8_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x [N],
    output logic [WIDTH-1:0] y [N]
);

    for (genvar gi = 0; gi < N; gi++) begin : g_perm
        assign y[gi] = x[BITREV_IDX[gi]];
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame controller for the 8-point FFT: counts samples, snapshots the shift
// register taps bit-reversed, and hands frames off with overrun detection.
// Define FFT8_OVERLAP_EN for 50 % overlapping frames (hop of 4 samples).
module fft8_frame_ctrl
    import fft8_frame_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sample_in,
    input  logic              sample_valid,
    output logic [WIDTH-1:0]  sr_data,
    output logic              sr_en,
    input  logic [WIDTH-1:0]  tap_0,
    input  logic [WIDTH-1:0]  tap_1,
    input  logic [WIDTH-1:0]  tap_2,
    input  logic [WIDTH-1:0]  tap_3,
    input  logic [WIDTH-1:0]  tap_4,
    input  logic [WIDTH-1:0]  tap_5,
    input  logic [WIDTH-1:0]  tap_6,
    input  logic [WIDTH-1:0]  tap_7,
    fft8_frame_ctrl_if.master frame_bus,
    output logic              overrun,
    output logic              overrun_sticky,
    output logic [FCNT_W-1:0] frame_count
);

`ifdef FFT8_OVERLAP_EN
    localparam logic [3:0] HOP_BASE = 4'd4;
`else
    localparam logic [3:0] HOP_BASE = 4'd0;
`endif
    localparam logic [3:0] FILL_LAST = 4'(N - 1);

    state_t            state_reg;
    logic [3:0]        fill_cnt_reg;
    logic [WIDTH-1:0]  frame_reg [N];
    logic              frame_valid_reg;
    logic              overrun_reg;
    logic              overrun_sticky_reg;
    logic [FCNT_W-1:0] frame_count_reg;

    logic [WIDTH-1:0]  x_natural [N];
    logic [WIDTH-1:0]  frame_next [N];
    logic              handshake;
    logic              buffer_free;

    assign sr_data = sample_in;
    assign sr_en   = sample_valid;

    // tap_0 is the newest sample, so natural order runs tap_7 down to tap_0.
    assign x_natural[0] = tap_7;
    assign x_natural[1] = tap_6;
    assign x_natural[2] = tap_5;
    assign x_natural[3] = tap_4;
    assign x_natural[4] = tap_3;
    assign x_natural[5] = tap_2;
    assign x_natural[6] = tap_1;
    assign x_natural[7] = tap_0;

    fft8_bitrev #(
        .WIDTH (WIDTH)
    ) u_bitrev (
        .x (x_natural),
        .y (frame_next)
    );

    assign handshake   = frame_valid_reg && frame_bus.frame_ready;
    assign buffer_free = !frame_valid_reg || frame_bus.frame_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_FILL;
            fill_cnt_reg       <= 4'd0;
            frame_valid_reg    <= 1'b0;
            overrun_reg        <= 1'b0;
            overrun_sticky_reg <= 1'b0;
            frame_count_reg    <= '0;
            for (int i = 0; i < N; i++) begin
                frame_reg[i] <= '0;
            end
        end else begin
            overrun_reg <= 1'b0;
            if (handshake) begin
                frame_valid_reg <= 1'b0;
            end
            case (state_reg)
                ST_FILL: begin
                    if (sample_valid) begin
                        if (fill_cnt_reg == FILL_LAST) begin
                            state_reg    <= ST_CAP;
                            fill_cnt_reg <= HOP_BASE;
                        end else begin
                            fill_cnt_reg <= fill_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_CAP: begin
                    // A sample landing here already belongs to the next frame.
                    if (sample_valid) begin
                        fill_cnt_reg <= fill_cnt_reg + 4'd1;
                    end
                    if (buffer_free) begin
                        for (int i = 0; i < N; i++) begin
                            frame_reg[i] <= frame_next[i];
                        end
                        frame_valid_reg <= 1'b1;
                        frame_count_reg <= frame_count_reg + FCNT_W'(1);
                    end else begin
                        overrun_reg        <= 1'b1;
                        overrun_sticky_reg <= 1'b1;
                    end
                    state_reg <= ST_FILL;
                end
                default: state_reg <= ST_FILL;
            endcase
        end
    end

    assign frame_bus.frame_0     = frame_reg[0];
    assign frame_bus.frame_1     = frame_reg[1];
    assign frame_bus.frame_2     = frame_reg[2];
    assign frame_bus.frame_3     = frame_reg[3];
    assign frame_bus.frame_4     = frame_reg[4];
    assign frame_bus.frame_5     = frame_reg[5];
    assign frame_bus.frame_6     = frame_reg[6];
    assign frame_bus.frame_7     = frame_reg[7];
    assign frame_bus.frame_valid = frame_valid_reg;

    assign overrun        = overrun_reg;
    assign overrun_sticky = overrun_sticky_reg;
    assign frame_count    = frame_count_reg;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a behavioural 8-tap shift register.
module tb_fft8_frame_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [7:0] sr_data;
    logic       sr_en;
    logic [7:0] tap [8];
    logic       overrun;
    logic       overrun_sticky;
    logic [7:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    fft8_frame_ctrl_if #(.WIDTH(8)) frame_bus ();

    fft8_frame_ctrl #(
        .WIDTH  (8),
        .FCNT_W (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sr_data        (sr_data),
        .sr_en          (sr_en),
        .tap_0          (tap[0]),
        .tap_1          (tap[1]),
        .tap_2          (tap[2]),
        .tap_3          (tap[3]),
        .tap_4          (tap[4]),
        .tap_5          (tap[5]),
        .tap_6          (tap[6]),
        .tap_7          (tap[7]),
        .frame_bus      (frame_bus),
        .overrun        (overrun),
        .overrun_sticky (overrun_sticky),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift register model (no reset, as in the real datapath).
    always @(posedge clk) begin
        if (sr_en) begin
            tap[0] <= sr_data;
            for (int i = 1; i < 8; i++) tap[i] <= tap[i-1];
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        sample_valid = v;
        sample_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset: valid=%0b count=%0d sticky=%0b", frame_bus.frame_valid, frame_count, overrun_sticky);
        n_checks++; if (frame_bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", frame_bus.frame_valid); end
        n_checks++; if (frame_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
        n_checks++; if (overrun !== 1'b0 || overrun_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %0b/%0b expected 0/0", overrun, overrun_sticky); end
        n_checks++; if (frame_bus.frame_0 !== 8'd0 || frame_bus.frame_7 !== 8'd0) begin n_fail++; $display("FAIL reset_frame: got %0d/%0d expected 0/0", frame_bus.frame_0, frame_bus.frame_7); end
    endtask

    task automatic test_passthrough();
        sample_in = 8'hA5; sample_valid = 1'b1;
        #1;
        $display("test_passthrough: sr_data=%0h sr_en=%0b", sr_data, sr_en);
        n_checks++; if (sr_data !== 8'hA5 || sr_en !== 1'b1) begin n_fail++; $display("FAIL passthrough: got %0h/%0b expected a5/1", sr_data, sr_en); end
        sample_valid = 1'b0;
        #1;
        n_checks++; if (sr_en !== 1'b0) begin n_fail++; $display("FAIL passthrough_en: got %0b expected 0", sr_en); end
    endtask

    task automatic test_single_frame();
        do_reset();
        frame_bus.frame_ready = 1'b1;
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k));
        n_checks++; if (frame_bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b expected 0", frame_bus.frame_valid); end
        step(1'b0, 8'd0);
        $display("test_single_frame: %0d %0d %0d %0d %0d %0d %0d %0d valid=%0b count=%0d",
                 frame_bus.frame_0, frame_bus.frame_1, frame_bus.frame_2, frame_bus.frame_3,
                 frame_bus.frame_4, frame_bus.frame_5, frame_bus.frame_6, frame_bus.frame_7,
                 frame_bus.frame_valid, frame_count);
        n_checks++; if (frame_bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", frame_bus.frame_valid); end
        n_checks++; if ({frame_bus.frame_0, frame_bus.frame_1, frame_bus.frame_2, frame_bus.frame_3} !== {8'd1, 8'd5, 8'd3, 8'd7}) begin n_fail++; $display("FAIL single_lo: got %0d %0d %0d %0d expected 1 5 3 7", frame_bus.frame_0, frame_bus.frame_1, frame_bus.frame_2, frame_bus.frame_3); end
        n_checks++; if ({frame_bus.frame_4, frame_bus.frame_5, frame_bus.frame_6, frame_bus.frame_7} !== {8'd2, 8'd6, 8'd4, 8'd8}) begin n_fail++; $display("FAIL single_hi: got %0d %0d %0d %0d expected 2 6 4 8", frame_bus.frame_4, frame_bus.frame_5, frame_bus.frame_6, frame_bus.frame_7); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", frame_count); end
        step(1'b0, 8'd0);
        n_checks++; if (frame_bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_handoff: got %0b expected 0", frame_bus.frame_valid); end
    endtask

    task automatic test_mid_reset();
        int seen;
        do_reset();
        frame_bus.frame_ready = 1'b1;
        for (int k = 1; k <= 7; k++) step(1'b1, 8'(k));
        do_reset();
        seen = 0;
        for (int k = 10; k <= 17; k++) begin
            step(1'b1, 8'(k));
            if (frame_bus.frame_valid) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_early: got %0d valid cycles expected 0", seen); end
        step(1'b0, 8'd0);
        $display("test_mid_reset: f0=%0d f7=%0d valid=%0b count=%0d", frame_bus.frame_0, frame_bus.frame_7, frame_bus.frame_valid, frame_count);
        n_checks++; if (frame_bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid: got %0b expected 1", frame_bus.frame_valid); end
        n_checks++; if (frame_bus.frame_0 !== 8'd10 || frame_bus.frame_7 !== 8'd17) begin n_fail++; $display("FAIL midrst_frame: got %0d/%0d expected 10/17", frame_bus.frame_0, frame_bus.frame_7); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_overrun();
        int early;
        do_reset();
        frame_bus.frame_ready = 1'b0;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k));
            if (overrun) early++;
        end
        n_checks++; if (early !== 0) begin n_fail++; $display("FAIL ovr_early: got %0d pulses expected 0", early); end
        step(1'b0, 8'd0);
        $display("test_overrun: overrun=%0b sticky=%0b f0=%0d f7=%0d count=%0d", overrun, overrun_sticky, frame_bus.frame_0, frame_bus.frame_7, frame_count);
        n_checks++; if (overrun !== 1'b1 || overrun_sticky !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %0b/%0b expected 1/1", overrun, overrun_sticky); end
        step(1'b0, 8'd0);
        n_checks++; if (overrun !== 1'b0 || overrun_sticky !== 1'b1) begin n_fail++; $display("FAIL ovr_oneshot: got %0b/%0b expected 0/1", overrun, overrun_sticky); end
        n_checks++; if (frame_bus.frame_0 !== 8'd1 || frame_bus.frame_7 !== 8'd8 || frame_bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held: got %0d/%0d/%0b expected 1/8/1", frame_bus.frame_0, frame_bus.frame_7, frame_bus.frame_valid); end
        n_checks++; if (frame_count !== 8'd1) begin n_fail++; $display("FAIL ovr_count: got %0d expected 1", frame_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        n_checks++; if (overrun_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_sticky_rst: got %0b expected 0", overrun_sticky); end
        frame_bus.frame_ready = 1'b0;
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k));
        step(1'b0, 8'd0);
        for (int k = 9; k <= 16; k++) step(1'b1, 8'(k));
        n_checks++; if (frame_bus.frame_0 !== 8'd1 || frame_bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_hold: got %0d/%0b expected 1/1", frame_bus.frame_0, frame_bus.frame_valid); end
        frame_bus.frame_ready = 1'b1;
        step(1'b0, 8'd0);
        frame_bus.frame_ready = 1'b0;
        $display("test_back_to_back: f0=%0d f7=%0d valid=%0b overrun=%0b count=%0d", frame_bus.frame_0, frame_bus.frame_7, frame_bus.frame_valid, overrun, frame_count);
        n_checks++; if (frame_bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b expected 1", frame_bus.frame_valid); end
        n_checks++; if (frame_bus.frame_0 !== 8'd9 || frame_bus.frame_7 !== 8'd16) begin n_fail++; $display("FAIL b2b_frame: got %0d/%0d expected 9/16", frame_bus.frame_0, frame_bus.frame_7); end
        n_checks++; if (overrun !== 1'b0 || overrun_sticky !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %0b/%0b expected 0/0", overrun, overrun_sticky); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_gapped();
        int seen;
        do_reset();
        frame_bus.frame_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'(k));
            if (k < 8) begin step(1'b0, 8'd0); step(1'b0, 8'd0); end
        end
        step(1'b1, 8'd9);
        n_checks++; if (frame_bus.frame_valid !== 1'b1 || frame_bus.frame_0 !== 8'd1 || frame_bus.frame_7 !== 8'd8) begin n_fail++; $display("FAIL gap_first: got %0b/%0d/%0d expected 1/1/8", frame_bus.frame_valid, frame_bus.frame_0, frame_bus.frame_7); end
        step(1'b0, 8'd0);
        step(1'b0, 8'd0);
        seen = 0;
        for (int k = 10; k <= 16; k++) begin
            step(1'b1, 8'(k));
            if (frame_bus.frame_valid) seen++;
            if (k < 16) begin step(1'b0, 8'd0); step(1'b0, 8'd0); end
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL gap_early: got %0d valid cycles expected 0", seen); end
        step(1'b0, 8'd0);
        $display("test_gapped: f0=%0d f7=%0d valid=%0b count=%0d", frame_bus.frame_0, frame_bus.frame_7, frame_bus.frame_valid, frame_count);
        n_checks++; if (frame_bus.frame_valid !== 1'b1 || frame_bus.frame_0 !== 8'd9 || frame_bus.frame_7 !== 8'd16) begin n_fail++; $display("FAIL gap_second: got %0b/%0d/%0d expected 1/9/16", frame_bus.frame_valid, frame_bus.frame_0, frame_bus.frame_7); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL gap_count: got %0d expected 2", frame_count); end
    endtask

    task automatic test_overlap();
        do_reset();
        frame_bus.frame_ready = 1'b1;
        for (int k = 1; k <= 9; k++) step(1'b1, 8'(k));
        n_checks++; if (frame_bus.frame_valid !== 1'b1 || frame_bus.frame_0 !== 8'd1 || frame_bus.frame_7 !== 8'd8) begin n_fail++; $display("FAIL ovl_first: got %0b/%0d/%0d expected 1/1/8", frame_bus.frame_valid, frame_bus.frame_0, frame_bus.frame_7); end
        for (int k = 10; k <= 12; k++) step(1'b1, 8'(k));
        step(1'b0, 8'd0);
        $display("test_overlap: f0=%0d f7=%0d valid=%0b count=%0d", frame_bus.frame_0, frame_bus.frame_7, frame_bus.frame_valid, frame_count);
        n_checks++; if (frame_bus.frame_valid !== 1'b1 || frame_bus.frame_0 !== 8'd5 || frame_bus.frame_7 !== 8'd12) begin n_fail++; $display("FAIL ovl_second: got %0b/%0d/%0d expected 1/5/12", frame_bus.frame_valid, frame_bus.frame_0, frame_bus.frame_7); end
        n_checks++; if (frame_count !== 8'd2) begin n_fail++; $display("FAIL ovl_count: got %0d expected 2", frame_count); end
    endtask

    initial begin
        rst = 1'b1;
        sample_in = 8'd0;
        sample_valid = 1'b0;
        frame_bus.frame_ready = 1'b0;
        test_reset();
        test_passthrough();
        test_single_frame();
`ifdef FFT8_OVERLAP_EN
        test_overlap();
`else
        test_mid_reset();
        test_overrun();
        test_back_to_back();
        test_gapped();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
